window3x3_gen: RTL and testbench

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/window3x3_gen_pkg.sv | 27 ++
 rtl/window3x3_gen_line_buffer.sv | 42 ++++
 rtl/window3x3_gen.sv | 192 +++++++++++++++++++
 tb/tb_window3x3_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/window3x3_gen_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared image-pipeline definitions for the 3x3 window generator:
//   IMG_W / IMG_H / PIX_W : default frame geometry and pixel width
//   pixel_t               : one grayscale pixel
//   coord_t               : 10-bit pixel coordinate
//   has_full_window()     : true when a pixel at (x,y) completes a 3x3
//                           window whose rows and columns all belong to
//                           the current frame
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int IMG_W   = 640;
    localparam int IMG_H   = 480;
    localparam int PIX_W   = 4;
    localparam int COORD_W = 10;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [COORD_W-1:0] coord_t;

    // The newest pixel closes a window only once two earlier columns of the
    // same row and two earlier rows of the same frame exist.
    function automatic logic has_full_window(input coord_t x, input coord_t y);
        return (x >= 10'd2) && (y >= 10'd2);
    endfunction

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image line of pixel storage with a registered (1-cycle) read.
// Read and write in the same cycle to the same address return the old
// contents (read-first). No reset on the array so it maps onto block RAM.
// Ports:
//   GCLK    : clock, rising edge
//   rd_en   : read strobe; rd_data updates only when set
//   rd_addr : read address (pixel column)
//   rd_data : registered read data
//   wr_en   : write strobe
//   wr_addr : write address (pixel column)
//   wr_data : data written
// ---------------------------------------------------------------------------
module line_buffer
    import img_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = 4
) (
    input  logic          GCLK,
    input  logic          rd_en,
    input  coord_t        rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          wr_en,
    input  coord_t        wr_addr,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] mem [DEPTH];

    // Read-first RAM access: the read samples the array before this edge's write.
    always_ff @(posedge GCLK) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window3x3_gen.sv
// ---------------------------------------------------------------------------
// window3x3_gen
// Builds a sliding 3x3 pixel window from a raster-order grayscale stream.
// Two line buffers hold the rows above the current one; a two-column shift
// register plus the freshly assembled column form the window. Only windows
// whose centre is an interior pixel are emitted, 2 cycles after the pixel
// that completes them is accepted.
// Ports:
//   GCLK       : clock, rising edge
//   reset      : asynchronous, active-high reset
//   sof        : marks the accepted pixel as (0,0)
//   pix_valid  : pixel strobe (no backpressure)
//   pix_data   : grayscale pixel
//   win_valid  : one-cycle strobe, window outputs valid
//   win        : 3x3 window, element 3*r+c at [PIX_W*k +: PIX_W], r=0 top
//   win_x      : centre column
//   win_y      : centre row
//   frame_done : one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module window3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_W = img_pkg::IMG_W,
    parameter int IMG_H = img_pkg::IMG_H,
    parameter int PIX_W = img_pkg::PIX_W
) (
    input  logic               GCLK,
    input  logic               reset,
    input  logic               sof,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win,
    output coord_t             win_x,
    output coord_t             win_y,
    output logic               frame_done
);

    localparam coord_t LAST_X = coord_t'(IMG_W - 1);
    localparam coord_t LAST_Y = coord_t'(IMG_H - 1);

    // Input position counters: position of the next pixel to be accepted.
    coord_t x_r;
    coord_t y_r;
    // Position of the pixel on the input this cycle (sof forces the origin).
    coord_t cur_x_s;
    coord_t cur_y_s;

    // Stage 1: accepted pixel and its position, aligned with line-buffer reads.
    logic             v1_r;
    coord_t           x1_r;
    coord_t           y1_r;
    logic [PIX_W-1:0] pix1_r;

    logic [PIX_W-1:0] buf0_q;   // row y-1 at column x1
    logic [PIX_W-1:0] buf1_q;   // row y-2 at column x1

    // Shift register columns packed {top, middle, bottom}; col0 is leftmost.
    logic [3*PIX_W-1:0] col0_r;
    logic [3*PIX_W-1:0] col1_r;
    logic [3*PIX_W-1:0] new_col_s;
    logic [9*PIX_W-1:0] win_s;

    // Resolve the position of the current input pixel.
    always_comb begin
        if (sof) begin
            cur_x_s = 10'd0;
            cur_y_s = 10'd0;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
    end

    // Raster counters with row/frame wrap and end-of-frame pulse.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_valid) begin
                if (cur_x_s == LAST_X) begin
                    x_r <= 10'd0;
                    if (cur_y_s == LAST_Y) begin
                        y_r        <= 10'd0;
                        frame_done <= 1'b1;
                    end else begin
                        y_r <= cur_y_s + 10'd1;
                    end
                end else begin
                    x_r <= cur_x_s + 10'd1;
                    y_r <= cur_y_s;
                end
            end
        end
    end

    // Stage 1 pipeline register, matching the 1-cycle line-buffer read.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            v1_r   <= 1'b0;
            x1_r   <= 10'd0;
            y1_r   <= 10'd0;
            pix1_r <= '0;
        end else begin
            v1_r <= pix_valid;
            if (pix_valid) begin
                x1_r   <= cur_x_s;
                y1_r   <= cur_y_s;
                pix1_r <= pix_data;
            end
        end
    end

    // Buffer 0 holds row y-1: read the old pixel and store the new one at x.
    line_buffer #(
        .DEPTH (IMG_W),
        .DW    (PIX_W)
    ) u_buf0 (
        .GCLK    (GCLK),
        .rd_en   (pix_valid),
        .rd_addr (cur_x_s),
        .rd_data (buf0_q),
        .wr_en   (pix_valid),
        .wr_addr (cur_x_s),
        .wr_data (pix_data)
    );

    // Buffer 1 holds row y-2. Its write data is buffer 0's displaced pixel,
    // which only exists after buffer 0's registered read, so the write lands
    // one cycle later at the stage-1 column. A following read of the same
    // column can only come from a sof restart, whose first two rows never
    // produce a window, so the late write is never observed.
    line_buffer #(
        .DEPTH (IMG_W),
        .DW    (PIX_W)
    ) u_buf1 (
        .GCLK    (GCLK),
        .rd_en   (pix_valid),
        .rd_addr (cur_x_s),
        .rd_data (buf1_q),
        .wr_en   (v1_r),
        .wr_addr (x1_r),
        .wr_data (buf0_q)
    );

    assign new_col_s = {buf1_q, buf0_q, pix1_r};

    // Assemble the window: column c=0 is oldest, row r=0 is the top row.
    always_comb begin
        win_s = '0;
        for (int r = 0; r < 3; r++) begin
            win_s[PIX_W*(3*r+0) +: PIX_W] = col0_r[PIX_W*(2-r) +: PIX_W];
            win_s[PIX_W*(3*r+1) +: PIX_W] = col1_r[PIX_W*(2-r) +: PIX_W];
            win_s[PIX_W*(3*r+2) +: PIX_W] = new_col_s[PIX_W*(2-r) +: PIX_W];
        end
    end

    // Column shift register; stale columns across a row wrap are masked by x>=2.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            col0_r <= '0;
            col1_r <= '0;
        end else if (v1_r) begin
            col0_r <= col1_r;
            col1_r <= new_col_s;
        end else begin
            col0_r <= col0_r;
            col1_r <= col1_r;
        end
    end

    // Output registers: update only for interior centres, hold otherwise.
    always_ff @(posedge GCLK or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
            win       <= '0;
            win_x     <= 10'd0;
            win_y     <= 10'd0;
        end else if (v1_r && has_full_window(x1_r, y1_r)) begin
            win_valid <= 1'b1;
            win       <= win_s;
            win_x     <= x1_r - 10'd1;
            win_y     <= y1_r - 10'd1;
        end else begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen on a small 8x6 frame. The driver keeps
// its own copy of the frame and pushes the expected window for every pixel
// that should complete one; the monitor pops on each win_valid.
module tb_window3x3_gen;
    import img_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int P = 4;

    logic             GCLK = 1'b0;
    logic             reset;
    logic             sof;
    logic             pix_valid;
    logic [P-1:0]     pix_data;
    logic             win_valid;
    logic [9*P-1:0]   win;
    logic [9:0]       win_x;
    logic [9:0]       win_y;
    logic             frame_done;

    window3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .GCLK       (GCLK),
        .reset      (reset),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .win_valid  (win_valid),
        .win        (win),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        logic [9*P-1:0] w;
        logic [9:0]     x;
        logic [9:0]     y;
        int             acc;
    } exp_t;

    exp_t           q[$];
    int             fdq[$];
    logic [P-1:0]   img [H][W];
    int             bx = 0;
    int             by = 0;
    int             edge_cnt = 0;
    int             total = 0;
    int             bad = 0;
    int             win_seen = 0;
    int             fd_seen = 0;
    logic           cap_first = 1'b0;
    logic [9*P-1:0] first_win = '0;
    int             first_x = 0;
    int             first_y = 0;
    int             last_x = 0;
    int             last_y = 0;
    logic [9*P-1:0] prev_w = '0;
    logic [9:0]     prev_x = '0;
    logic [9:0]     prev_y = '0;

    always @(posedge GCLK) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one pixel after `gap` idle cycles and record its expectations.
    task automatic send(input logic s, input int gap);
        exp_t         e;
        logic [P-1:0] p;
        int           acc;
        for (int i = 0; i < gap; i++) begin
            @(negedge GCLK);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
        if (s) begin
            bx = 0;
            by = 0;
        end
        p = P'((bx + by) % 16);
        img[by][bx] = p;
        @(negedge GCLK);
        sof       = s;
        pix_valid = 1'b1;
        pix_data  = p;
        acc       = edge_cnt + 1;
        if (bx >= 2 && by >= 2) begin
            e.w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[P*(3*r+c) +: P] = img[by-2+r][bx-2+c];
            e.x   = 10'(bx - 1);
            e.y   = 10'(by - 1);
            e.acc = acc;
            q.push_back(e);
        end
        if (bx == W-1 && by == H-1) fdq.push_back(acc);
        bx++;
        if (bx == W) begin
            bx = 0;
            by++;
            if (by == H) by = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge GCLK);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    // Monitor: pop and compare on each window strobe, check frame_done and hold.
    always @(negedge GCLK) begin
        exp_t e;
        if (reset) begin
            prev_w = '0;
            prev_x = '0;
            prev_y = '0;
        end else if (win_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_win: got centre (%0d,%0d) want none", win_x, win_y);
            end else begin
                e = q.pop_front();
                chk("win", 64'(win), 64'(e.w));
                chk("win_x", 64'(win_x), 64'(e.x));
                chk("win_y", 64'(win_y), 64'(e.y));
                chk("latency", 64'(edge_cnt), 64'(e.acc + 1));
                win_seen++;
                if (cap_first) begin
                    first_win = win;
                    first_x   = int'(win_x);
                    first_y   = int'(win_y);
                    cap_first = 1'b0;
                end
                last_x = int'(win_x);
                last_y = int'(win_y);
            end
            prev_w = win;
            prev_x = win_x;
            prev_y = win_y;
        end else begin
            chk("hold_win", 64'(win), 64'(prev_w));
            chk("hold_xy", 64'({win_x, win_y}), 64'({prev_x, prev_y}));
        end
        if (frame_done && !reset) begin
            fd_seen++;
            if (fdq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_frame_done: got 1 want 0 at edge %0d", edge_cnt);
            end else begin
                chk("frame_done_lat", 64'(edge_cnt), 64'(fdq.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws0;
        int fd0;
        reset     = 1'b1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (3) @(negedge GCLK);
        chk("rst_win_valid", 64'(win_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_win", 64'(win), 64'd0);
        chk("rst_win_xy", 64'({win_x, win_y}), 64'd0);
        #1 reset = 1'b0;

        // Frame 1: continuous ramp, then one wrap pixel that must not emit.
        ws0 = win_seen; fd0 = fd_seen; cap_first = 1'b1;
        for (int i = 0; i < W*H; i++) send(i == 0, 0);
        send(1'b0, 0);
        idle(5);
        chk("f1_count", 64'(win_seen - ws0), 64'((W-2)*(H-2)));
        chk("f1_first_win", 64'(first_win), 64'h4_3232_1210);
        chk("f1_first_xy", 64'({first_x[9:0], first_y[9:0]}), 64'({10'd1, 10'd1}));
        chk("f1_last_xy", 64'({last_x[9:0], last_y[9:0]}), 64'({10'(W-2), 10'(H-2)}));
        chk("f1_frame_done", 64'(fd_seen - fd0), 64'd1);

        // Frame 2: same ramp with directed 0-5 cycle gaps.
        ws0 = win_seen; fd0 = fd_seen; cap_first = 1'b1;
        for (int i = 0; i < W*H; i++) send(i == 0, (i * 5 + 3) % 6);
        idle(5);
        chk("f2_count", 64'(win_seen - ws0), 64'((W-2)*(H-2)));
        chk("f2_first_win", 64'(first_win), 64'h4_3232_1210);
        chk("f2_frame_done", 64'(fd_seen - fd0), 64'd1);

        // Short frame: restart with sof at (5,3).
        for (int i = 0; i < 3*W + 5; i++) send(i == 0, 0);
        idle(4);
        ws0 = win_seen; fd0 = fd_seen; cap_first = 1'b1;
        for (int i = 0; i < W*H; i++) send(i == 0, i % 2);
        idle(5);
        chk("sof_first_xy", 64'({first_x[9:0], first_y[9:0]}), 64'({10'd1, 10'd1}));
        chk("sof_first_win", 64'(first_win), 64'h4_3232_1210);
        chk("sof_count", 64'(win_seen - ws0), 64'((W-2)*(H-2)));
        chk("sof_frame_done", 64'(fd_seen - fd0), 64'd1);

        // Reset mid-frame at (5,3): in-flight windows are dropped.
        for (int i = 0; i < 3*W + 6; i++) send(i == 0, 0);
        @(negedge GCLK);
        #1;
        reset = 1'b1;
        pix_valid = 1'b0;
        sof = 1'b0;
        q.delete();
        fdq.delete();
        bx = 0;
        by = 0;
        repeat (2) @(negedge GCLK);
        chk("mid_rst_win_valid", 64'(win_valid), 64'd0);
        chk("mid_rst_win", 64'(win), 64'd0);
        chk("mid_rst_xy", 64'({win_x, win_y}), 64'd0);
        #1 reset = 1'b0;
        ws0 = win_seen; fd0 = fd_seen; cap_first = 1'b1;
        for (int i = 0; i < W*H; i++) send(i == 0, 0);
        idle(5);
        chk("rst_frame_count", 64'(win_seen - ws0), 64'((W-2)*(H-2)));
        chk("rst_frame_first_xy", 64'({first_x[9:0], first_y[9:0]}), 64'({10'd1, 10'd1}));
        chk("rst_frame_done", 64'(fd_seen - fd0), 64'd1);

        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("fd_queue_empty", 64'(fdq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
